ov7670_dvp_capture: RTL and testbench

- DVP front-end for the OV7670. Runs in the camera pixel-clock domain.
- Samples vsync, href and the 8-bit data bus, and pairs bytes into 16-bit pixels (first byte = high byte, RGB565/YUV422).
- Counts x/y position, applies a crop window and produces a pixel stream with frame strobes.
- Feeds the frame-buffer writer; on request it captures a single frame or runs continuously.

---
 rtl/ov7670_dvp_capture_if.sv | 30 +++
 rtl/ov7670_dvp_capture.sv | 216 +++++++++++++++++++++
 tb/tb_ov7670_dvp_capture.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_dvp_capture_if.sv
// Camera-side DVP bus, capture control and pixel-stream outputs of the OV7670 front-end.
// master drives the camera pins and control inputs; slave is the capture block.
interface ov7670_dvp_capture_if;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        capture_req;
    logic        continuous;
    logic        busy;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_last;

    modport master (
        output cam_vsync, cam_href, cam_data, capture_req, continuous,
        input  busy, frame_start, frame_done, frame_err,
        input  pix_valid, pix_data, pix_x, pix_y, pix_last
    );

    modport slave (
        input  cam_vsync, cam_href, cam_data, capture_req, continuous,
        output busy, frame_start, frame_done, frame_err,
        output pix_valid, pix_data, pix_x, pix_y, pix_last
    );
endinterface

// File: rtl/ov7670_dvp_capture.sv
// OV7670 DVP capture: registers the camera bus, pairs bytes into 16-bit pixels,
// tracks x/y, crops, and frames single or continuous captures. Runs entirely on pclk.
//
// state     | meaning
// ST_IDLE   | no capture requested
// ST_SYNC   | waiting for vertical blanking so we never start mid-frame
// ST_ARMED  | in blanking, waiting for vsync to fall
// ST_ACTIVE | frame in progress, pixels emitted inside the crop window
// ST_FINISH | vsync rose; report frame_done/frame_err once the last line has closed
module ov7670_dvp_capture #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CROP_X0    = 0,
    parameter int CROP_Y0    = 0,
    parameter int CROP_W     = 640,
    parameter int CROP_H     = 480
) (
    input logic                 pclk,
    input logic                 system_reset,
    ov7670_dvp_capture_if.slave dvp
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ARMED,
        ST_ACTIVE,
        ST_FINISH
    } state_t;

    localparam logic [10:0] CX0   = 11'(CROP_X0);
    localparam logic [10:0] CY0   = 11'(CROP_Y0);
    localparam logic [10:0] CW    = 11'(CROP_W);
    localparam logic [10:0] CH    = 11'(CROP_H);
    localparam logic [9:0]  IMG_W = 10'(IMG_WIDTH);
    localparam logic [9:0]  IMG_H = 10'(IMG_HEIGHT);
    localparam logic [9:0]  SAT   = 10'h3FF;

    state_t      state_q, state_d;

    logic        vs_q, hr_q;
    logic [7:0]  d_q;
    logic        vs_p_q, hr_p_q;

    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        err_q, err_d;

    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;
    logic        pix_valid_q, pix_valid_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic [9:0]  pix_x_q, pix_x_d;
    logic [9:0]  pix_y_q, pix_y_d;
    logic        pix_last_q, pix_last_d;

    logic        vs_rise, vs_fall, hr_fall, pix_form, in_crop;
    logic [10:0] rel_x, rel_y;

    always_ff @(posedge pclk or posedge system_reset) begin
        if (system_reset) begin
            vs_q   <= 1'b0;
            hr_q   <= 1'b0;
            d_q    <= 8'd0;
            vs_p_q <= 1'b0;
            hr_p_q <= 1'b0;
        end else begin
            vs_q   <= dvp.cam_vsync;
            hr_q   <= dvp.cam_href;
            d_q    <= dvp.cam_data;
            vs_p_q <= vs_q;
            hr_p_q <= hr_q;
        end
    end

    assign vs_rise  = vs_q & ~vs_p_q;
    assign vs_fall  = ~vs_q & vs_p_q;
    assign hr_fall  = ~hr_q & hr_p_q;
    assign pix_form = hr_q & phase_q;

    // Columns/lines left of or above the window wrap to large values and fail the compare.
    assign rel_x   = {1'b0, x_q} - CX0;
    assign rel_y   = {1'b0, y_q} - CY0;
    assign in_crop = (rel_x < CW) && (rel_y < CH);

    always_comb begin
        state_d       = state_q;
        phase_d       = 1'b0;
        hi_d          = hi_q;
        x_d           = x_q;
        y_d           = y_q;
        err_d         = err_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = frame_err_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_last_d    = 1'b0;

        if (hr_q) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = d_q;
            end
        end

        if (pix_form && (x_q != SAT)) begin
            x_d = x_q + 10'd1;
        end

        // A set phase at line end means an odd byte count; the stray byte is discarded.
        if (hr_fall) begin
            x_d = '0;
            if ((x_q != '0) && (y_q != SAT)) begin
                y_d = y_q + 10'd1;
            end
            if (phase_q || (x_q != IMG_W)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (dvp.capture_req || dvp.continuous) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (vs_q) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vs_fall) begin
                    state_d       = ST_ACTIVE;
                    frame_start_d = 1'b1;
                    frame_err_d   = 1'b0;
                    x_d           = '0;
                    y_d           = '0;
                    err_d         = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (pix_form && in_crop) begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = {hi_q, d_q};
                    pix_x_d     = rel_x[9:0];
                    pix_y_d     = rel_y[9:0];
                    pix_last_d  = (rel_x == CW - 11'd1) && (rel_y == CH - 11'd1);
                end
                if (vs_rise) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // Next-cycle counters so a line closing this cycle is still judged.
                frame_done_d = 1'b1;
                frame_err_d  = err_d | (y_d != IMG_H);
                state_d      = dvp.continuous ? ST_ARMED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge system_reset) begin
        if (system_reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= 1'b0;
            hi_q          <= 8'd0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            err_q         <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= 16'd0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            x_q           <= x_d;
            y_q           <= y_d;
            err_q         <= err_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_last_q    <= pix_last_d;
        end
    end

    assign dvp.busy        = (state_q != ST_IDLE);
    assign dvp.frame_start = frame_start_q;
    assign dvp.frame_done  = frame_done_q;
    assign dvp.frame_err   = frame_err_q;
    assign dvp.pix_valid   = pix_valid_q;
    assign dvp.pix_data    = pix_data_q;
    assign dvp.pix_x       = pix_x_q;
    assign dvp.pix_y       = pix_y_q;
    assign dvp.pix_last    = pix_last_q;

endmodule

// File: tb/tb_ov7670_dvp_capture.sv
// Directed bench for ov7670_dvp_capture on an 8x4 image cropped to 4x2 at (2,1).
// Line y of a frame carries bytes step*y+1, step*y+2, ... so every pixel value is predictable.
module tb_ov7670_dvp_capture;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CX = 2;
    localparam int CY = 1;
    localparam int CW = 4;
    localparam int CH = 2;

    logic pclk = 1'b0;
    logic system_reset;

    ov7670_dvp_capture_if dvp ();

    ov7670_dvp_capture #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .CROP_X0   (CX),
        .CROP_Y0   (CY),
        .CROP_W    (CW),
        .CROP_H    (CH)
    ) dut (
        .pclk        (pclk),
        .system_reset(system_reset),
        .dvp         (dvp)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [15:0] data;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        last;
        int          cyc;
    } pix_t;

    pix_t pixq[$];
    pix_t rec;
    int   cyc = 0;
    int   fs_cnt = 0;
    int   fd_cnt = 0;
    logic last_err = 1'b0;
    int   busy_drop = 0;
    logic busy_mon = 1'b0;
    int   fd_mon_base = 0;
    int   b2_edge[0:3];
    int   checks = 0;
    int   failures = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (dvp.pix_valid) begin
            rec.data = dvp.pix_data;
            rec.x    = dvp.pix_x;
            rec.y    = dvp.pix_y;
            rec.last = dvp.pix_last;
            rec.cyc  = cyc;
            pixq.push_back(rec);
        end
        if (dvp.frame_start) fs_cnt <= fs_cnt + 1;
        if (dvp.frame_done) begin
            fd_cnt   <= fd_cnt + 1;
            last_err <= dvp.frame_err;
        end
        if (busy_mon && !dvp.busy && !dvp.frame_done && (fd_cnt - fd_mon_base) < 3)
            busy_drop <= busy_drop + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d, input logic req);
        @(negedge pclk);
        dvp.cam_vsync   = vs;
        dvp.cam_href    = hr;
        dvp.cam_data    = d;
        dvp.capture_req = req;
    endtask

    task automatic send_line(input logic [7:0] base, input int nbytes, input int yi);
        for (int k = 1; k <= nbytes; k++) begin
            drive(1'b0, 1'b1, 8'(int'(base) + k), 1'b0);
            if (k == 2 * CX + 2) b2_edge[yi] = cyc + 1;
        end
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // vsync low porch, H lines, porch, then vertical blanking long enough for frame_done.
    task automatic send_frame(input int odd_line, input int stop_cont_line, input logic [7:0] step);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int y = 0; y < H; y++) begin
            if (y == stop_cont_line) dvp.continuous = 1'b0;
            send_line(8'(y * int'(step)), (y == odd_line) ? 15 : 16, y);
        end
        repeat (6) drive(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_pixels(input int pb, input logic [7:0] step);
        check("pix_count", 32'(pixq.size() - pb), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (pb + i < pixq.size()) begin
                int px;
                int py;
                px = CX + i % CW;
                py = CY + i / CW;
                check("pix_data", {16'd0, pixq[pb + i].data},
                      {16'd0, 8'(py * int'(step) + 2 * px + 1), 8'(py * int'(step) + 2 * px + 2)});
                check("pix_pos", {11'd0, pixq[pb + i].x, pixq[pb + i].y, pixq[pb + i].last},
                      {11'd0, 10'(i % CW), 10'(i / CW), (i == 7)});
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {26'd0, dvp.busy, dvp.frame_start, dvp.frame_done,
                               dvp.frame_err, dvp.pix_valid, dvp.pix_last}, 32'd0);
        check({tag, "_data"}, {16'd0, dvp.pix_data}, 32'd0);
        check({tag, "_xy"}, {12'd0, dvp.pix_x, dvp.pix_y}, 32'd0);
    endtask

    initial begin
        int pb, fsb, fdb;

        system_reset    = 1'b0;
        dvp.cam_vsync   = 1'b1;
        dvp.cam_href    = 1'b0;
        dvp.cam_data    = 8'h00;
        dvp.capture_req = 1'b0;
        dvp.continuous  = 1'b0;
        for (int i = 0; i < 4; i++) b2_edge[i] = 0;
        #2 system_reset = 1'b1;
        repeat (3) @(negedge pclk);
        check_outputs_zero("reset");
        system_reset = 1'b0;
        repeat (4) drive(1'b1, 1'b0, 8'h00, 1'b0);
        check("idle_busy", {31'd0, dvp.busy}, 32'd0);

        // Single capture of a clean frame, including the pixel latency.
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        check("armed_busy", {31'd0, dvp.busy}, 32'd1);
        pb = pixq.size(); fsb = fs_cnt; fdb = fd_cnt;
        send_frame(-1, -1, 8'h00);
        check_pixels(pb, 8'h00);
        check("t1_fs", 32'(fs_cnt - fsb), 32'd1);
        check("t1_fd", 32'(fd_cnt - fdb), 32'd1);
        check("t1_err", {31'd0, last_err}, 32'd0);
        check("t1_busy", {31'd0, dvp.busy}, 32'd0);
        if (pixq.size() >= pb + 2) begin
            check("lat_first", 32'(pixq[pb].cyc), 32'(b2_edge[1] + 1));
            check("lat_next", 32'(pixq[pb + 1].cyc), 32'(b2_edge[1] + 3));
        end

        // Request during a frame in progress: that frame must be skipped.
        pb = pixq.size(); fsb = fs_cnt; fdb = fd_cnt;
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        send_line(8'h40, 16, 0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int y = 1; y < H; y++) send_line(8'h40, 16, y);
        repeat (6) drive(1'b1, 1'b0, 8'h00, 1'b0);
        check("mid_fs", 32'(fs_cnt - fsb), 32'd0);
        check("mid_fd", 32'(fd_cnt - fdb), 32'd0);
        check("mid_pix", 32'(pixq.size() - pb), 32'd0);
        check("mid_busy", {31'd0, dvp.busy}, 32'd1);
        send_frame(-1, -1, 8'h10);
        check_pixels(pb, 8'h10);
        check("mid_fs2", 32'(fs_cnt - fsb), 32'd1);
        check("mid_err", {31'd0, last_err}, 32'd0);

        // Odd-length line flags an error; the next clean frame clears it.
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        pb = pixq.size();
        send_frame(1, -1, 8'h10);
        check_pixels(pb, 8'h10);
        check("odd_err", {31'd0, last_err}, 32'd1);
        check("odd_err_held", {31'd0, dvp.frame_err}, 32'd1);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        pb = pixq.size();
        send_frame(-1, -1, 8'h10);
        check_pixels(pb, 8'h10);
        check("clean_err", {31'd0, last_err}, 32'd0);

        // Continuous mode over three frames, dropped during the third.
        dvp.continuous = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        pb = pixq.size(); fsb = fs_cnt; fdb = fd_cnt;
        fd_mon_base = fd_cnt;
        busy_mon = 1'b1;
        send_frame(-1, -1, 8'h10);
        send_frame(-1, -1, 8'h10);
        send_frame(-1, 2, 8'h10);
        busy_mon = 1'b0;
        check("cont_fs", 32'(fs_cnt - fsb), 32'd3);
        check("cont_fd", 32'(fd_cnt - fdb), 32'd3);
        check("cont_busy_drop", 32'(busy_drop), 32'd0);
        check("cont_pix", 32'(pixq.size() - pb), 32'd24);
        check("cont_err", {31'd0, last_err}, 32'd0);
        check("cont_idle", {31'd0, dvp.busy}, 32'd0);
        send_frame(-1, -1, 8'h10);
        check("cont_stopped", 32'(fs_cnt - fsb), 32'd3);

        // Reset in the middle of a cropped line.
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
        send_line(8'h00, 16, 0);
        for (int k = 1; k <= 12; k++) drive(1'b0, 1'b1, 8'(16 + k), 1'b0);
        check("pre_reset_busy", {31'd0, dvp.busy}, 32'd1);
        @(negedge pclk);
        system_reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (2) drive(1'b1, 1'b0, 8'h00, 1'b0);
        system_reset = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        check("post_reset_busy", {31'd0, dvp.busy}, 32'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0);
        pb = pixq.size(); fsb = fs_cnt; fdb = fd_cnt;
        send_frame(-1, -1, 8'h20);
        check_pixels(pb, 8'h20);
        check("rst_fs", 32'(fs_cnt - fsb), 32'd1);
        check("rst_fd", 32'(fd_cnt - fdb), 32'd1);
        check("rst_err", {31'd0, last_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
